// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, drives the synchronous
// instruction ROM and presents the fetched instruction on the IF/ID boundary.
// A stall that lands while a fetched word is in flight captures that word into
// a holding register (HOLD state), so the word presented to decode stays
// constant however long the stall lasts. A flush squashes the in-flight fetch
// and redirects the PC. A separate counter tracks instructions that decode
// accepts.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_npc,
    input  logic        i_stall,
    input  logic        i_flush,
    output logic [31:0] o_pc,
    output logic        o_irom_en,
    output logic [31:0] o_irom_addr,
    input  logic [31:0] i_irom_data,
    output logic        o_id_valid,
    output logic [31:0] o_id_pc,
    output logic [31:0] o_id_pc4,
    output logic [31:0] o_id_inst,
    output logic        o_misalign_err,
    output logic [31:0] o_fetch_count
);

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_f_pc;
    logic        r_f_valid;
    logic [31:0] r_hold_inst;
    logic        r_misalign_err;
    logic [31:0] r_fetch_count;

    logic        w_adv;
    logic        w_load;
    logic        w_accept;
    logic [31:0] w_npc_aligned;

    // Flush outranks stall; the PC is reloaded on every advance or flush.
    assign w_adv         = ~i_stall & ~i_flush;
    assign w_load        = ~i_stall | i_flush;
    assign w_accept      = r_f_valid & w_adv;
    assign w_npc_aligned = {i_npc[31:2], 2'b00};

    // Fetch PC, IF/ID slot, stall capture, sticky misalignment flag and
    // accepted-instruction counter.
    always_ff @(posedge i_clk) begin
        // NOTE: every register here uses non-blocking assignment so each one
        // sees the pre-edge value of the others (e.g. r_f_pc takes the old
        // r_pc while r_pc itself is being reloaded on the same edge).
        if (i_rst) begin
            r_state        <= RUN;
            r_pc           <= RESET_PC;
            r_f_pc         <= 32'd0;
            r_f_valid      <= 1'b0;
            r_hold_inst    <= 32'd0;
            r_misalign_err <= 1'b0;
            r_fetch_count  <= 32'd0;
        end else begin
            if (w_accept) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end

            if (w_load && (i_npc[1:0] != 2'b00)) begin
                r_misalign_err <= 1'b1;
            end

            if (i_flush) begin
                // The read (if any) issued last cycle is dropped by clearing
                // the slot; no read is issued during the flush cycle itself.
                r_f_valid <= 1'b0;
                r_pc      <= w_npc_aligned;
                r_state   <= RUN;
            end else if (!i_stall) begin
                r_f_pc    <= r_pc;
                r_f_valid <= 1'b1;
                r_pc      <= w_npc_aligned;
                r_state   <= RUN;
            end else if (r_state == RUN && r_f_valid) begin
                // First stall cycle with a live fetch: the ROM word is only
                // guaranteed now, so freeze a copy for the rest of the stall.
                r_hold_inst <= i_irom_data;
                r_state     <= HOLD;
            end
        end
    end

    // Outputs: ROM is read only on an advancing, non-reset cycle.
    assign o_pc           = r_pc;
    assign o_irom_addr    = r_pc;
    assign o_irom_en      = ~i_rst & w_adv;
    assign o_id_valid     = r_f_valid;
    assign o_id_pc        = r_f_pc;
    assign o_id_pc4       = r_f_pc + 32'd4;
    assign o_misalign_err = r_misalign_err;
    assign o_fetch_count  = r_fetch_count;

    // Instruction mux: bubble, captured word during/after a stall, or live ROM data.
    always_comb begin
        o_id_inst = i_irom_data;
        if (!r_f_valid) begin
            o_id_inst = NOP_INST;
        end else if (r_state == HOLD) begin
            o_id_inst = r_hold_inst;
        end
    end

endmodule
